// File: rtl/zbb_bitcount_seq.sv
// rtl/zbb_bitcount_seq.sv - multi-cycle CPOP/CLZ/CTZ engine, CHUNK operand bits per cycle
module zbb_bitcount_seq #(
   parameter int XLEN  = 32,
   parameter int CHUNK = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] operand_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int N     = XLEN / CHUNK;
   localparam int ACC_W = $clog2(XLEN) + 1;
   localparam int CW    = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [XLEN-1:0]   r_shift;
   logic [1:0]        r_op;
   logic [ACC_W-1:0]  r_acc;
   logic [CW-1:0]     r_cnt;
   logic              r_found;
   logic [XLEN-1:0]   r_result;

   logic [XLEN-1:0]   w_rev;
   logic [CHUNK-1:0]  w_chunk;
   logic [ACC_W-1:0]  w_ones;
   logic [ACC_W-1:0]  w_tz;
   logic              w_seen;
   logic              w_has_one;
   logic [ACC_W-1:0]  w_add;
   logic [ACC_W-1:0]  w_acc_next;
   logic              w_last;

   // CLZ is turned into CTZ by reversing the operand, so one LSB-first scan serves all ops
   always_comb begin
      w_rev = '0;
      for (int i = 0; i < XLEN; i++) begin
         w_rev[i] = operand_i[XLEN-1-i];
      end
   end

   assign w_chunk   = r_shift[CHUNK-1:0];
   assign w_has_one = |w_chunk;
   assign w_last    = (r_cnt == CW'(N - 1));

   always_comb begin
      w_ones = '0;
      w_tz   = ACC_W'(CHUNK);
      w_seen = 1'b0;
      for (int i = 0; i < CHUNK; i++) begin
         w_ones = w_ones + ACC_W'(w_chunk[i]);
         if (!w_seen && w_chunk[i]) begin
            w_tz   = ACC_W'(i);
            w_seen = 1'b1;
         end
      end
   end

   always_comb begin
      w_add = '0;
      case (r_op)
         2'b00:   w_add = w_ones;
         2'b01,
         2'b10:   w_add = r_found ? '0 : w_tz;
         default: w_add = '0;
      endcase
   end

   assign w_acc_next = r_acc + w_add;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      busy_o = 1'b0;
      done_o = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_i) w_next = S_BUSY;
         end
         S_BUSY: begin
            busy_o = 1'b1;
            if (w_last) w_next = S_DONE;
         end
         S_DONE: begin
            done_o = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift  <= '0;
         r_op     <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_found  <= 1'b0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_shift <= (op_i == 2'b01) ? w_rev : operand_i;
                  r_op    <= op_i;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_found <= 1'b0;
               end
            end
            S_BUSY: begin
               r_shift <= r_shift >> CHUNK;
               r_acc   <= w_acc_next;
               r_cnt   <= r_cnt + CW'(1);
               r_found <= r_found | w_has_one;
               if (w_last) begin
                  r_result <= {{(XLEN-ACC_W){1'b0}}, w_acc_next};
               end
            end
            default: ;
         endcase
      end
   end

   assign result_o = r_result;

endmodule

// File: tb/tb_zbb_bitcount_seq.sv
// tb/tb_zbb_bitcount_seq.sv - table, corner-sequence and random checks for zbb_bitcount_seq
module tb_zbb_bitcount_seq;

   localparam int XLEN = 32;
   localparam int N    = 8;

   logic            clk;
   logic            rst;
   logic            start_i;
   logic [1:0]      op_i;
   logic [XLEN-1:0] operand_i;
   logic            busy_o;
   logic            done_o;
   logic [XLEN-1:0] result_o;

   int n_checks = 0;
   int n_errors = 0;

   zbb_bitcount_seq #(.XLEN(XLEN), .CHUNK(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start_i),
      .op_i      (op_i),
      .operand_i (operand_i),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .result_o  (result_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] operand;
      logic [31:0] expected;
   } vec_t;

   function automatic logic [31:0] ref_count(input logic [1:0] op, input logic [31:0] x);
      int n;
      n = 0;
      case (op)
         2'b00: n = $countones(x);
         2'b01: begin
            for (int i = XLEN - 1; i >= 0; i--) begin
               if (x[i]) return 32'(n);
               n++;
            end
         end
         2'b10: begin
            for (int i = 0; i < XLEN; i++) begin
               if (x[i]) return 32'(n);
               n++;
            end
         end
         default: n = 0;
      endcase
      return 32'(n);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Launch one op from IDLE at a negedge, then observe 12 cycles of handshake
   task automatic do_op(input logic [1:0] op, input logic [31:0] x,
                        input logic [31:0] exp, input string tag);
      int busy_cnt, done_cnt, done_cyc;
      logic [31:0] res;
      busy_cnt = 0; done_cnt = 0; done_cyc = 0; res = '0;
      start_i = 1'b1; op_i = op; operand_i = x;
      @(posedge clk);
      #1 start_i = 1'b0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(negedge clk);
         if (busy_o) busy_cnt++;
         if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
            res = result_o;
         end
      end
      check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(N));
      check({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
      check({tag, " done_cycle"}, 32'(done_cyc), 32'(N + 1));
      check({tag, " result"}, res, exp);
   endtask

   vec_t vecs[13];

   initial begin
      vecs[0]  = '{2'b00, 32'h2F01C622, 32'd12};
      vecs[1]  = '{2'b00, 32'h28004020, 32'd4};
      vecs[2]  = '{2'b00, 32'hFFFFFFFF, 32'd32};
      vecs[3]  = '{2'b00, 32'h00000000, 32'd0};
      vecs[4]  = '{2'b01, 32'h2F01C622, 32'd2};
      vecs[5]  = '{2'b10, 32'h2F01C622, 32'd1};
      vecs[6]  = '{2'b01, 32'h28004020, 32'd2};
      vecs[7]  = '{2'b10, 32'h28004020, 32'd5};
      vecs[8]  = '{2'b01, 32'h80000000, 32'd0};
      vecs[9]  = '{2'b10, 32'h80000000, 32'd31};
      vecs[10] = '{2'b01, 32'h00000000, 32'd32};
      vecs[11] = '{2'b10, 32'h00000000, 32'd32};
      vecs[12] = '{2'b11, 32'hFFFFFFFF, 32'd0};

      rst = 1'b1; start_i = 1'b0; op_i = 2'b00; operand_i = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset busy", 32'(busy_o), 32'd0);
      check("reset done", 32'(done_o), 32'd0);
      check("reset result", result_o, 32'd0);

      for (int i = 0; i < 13; i++) begin
         do_op(vecs[i].op, vecs[i].operand, vecs[i].expected, $sformatf("vec%0d", i));
      end
      do_op(2'b10, 32'h00000001, 32'd0, "ctz_lsb");
      do_op(2'b01, 32'h00000001, 32'd31, "clz_lsb");
      do_op(2'b01, 32'hFFFFFFFF, 32'd0, "clz_ones");
      do_op(2'b10, 32'hFFFFFFFF, 32'd0, "ctz_ones");

      // Start held high with a churning operand/op through BUSY and DONE
      begin
         logic [31:0] a, b, got;
         int done_seen;
         a = 32'h2F01C622; b = 32'h0000F000;
         start_i = 1'b1; op_i = 2'b00; operand_i = a;
         @(posedge clk);
         for (int cyc = 1; cyc <= N + 1; cyc++) begin
            @(negedge clk);
            if (cyc == N + 1) begin
               check("ign done", 32'(done_o), 32'd1);
               check("ign result", result_o, ref_count(2'b00, a));
            end
            operand_i = $urandom; op_i = 2'($urandom_range(0, 3));
         end
         @(negedge clk);
         check("ign idle busy", 32'(busy_o), 32'd0);
         check("ign idle result", result_o, ref_count(2'b00, a));
         op_i = 2'b01; operand_i = b;
         @(posedge clk);
         #1 start_i = 1'b0; operand_i = 32'hFFFFFFFF;
         @(negedge clk);
         check("restart busy", 32'(busy_o), 32'd1);
         done_seen = 0; got = '0;
         for (int cyc = 0; cyc < 15 && done_seen == 0; cyc++) begin
            @(negedge clk);
            if (done_o) begin done_seen = 1; got = result_o; end
         end
         check("restart done seen", 32'(done_seen), 32'd1);
         check("restart result", got, ref_count(2'b01, b));
         repeat (2) @(negedge clk);
      end

      // Reset in the middle of a scan
      begin
         int done_cnt;
         do_op(2'b00, 32'hFFFFFFFF, 32'd32, "pre_rst");
         start_i = 1'b1; op_i = 2'b00; operand_i = 32'h0F0F0F0F;
         @(posedge clk);
         #1 start_i = 1'b0;
         repeat (3) @(posedge clk);
         @(negedge clk);
         check("mid busy", 32'(busy_o), 32'd1);
         rst = 1'b1;
         #1;
         check("rst busy", 32'(busy_o), 32'd0);
         check("rst done", 32'(done_o), 32'd0);
         check("rst result", result_o, 32'd0);
         done_cnt = 0;
         repeat (2) @(negedge clk);
         rst = 1'b0;
         for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (done_o) done_cnt++;
         end
         check("aborted no done", 32'(done_cnt), 32'd0);
         do_op(2'b10, 32'h00000100, 32'd8, "post_rst");
      end

      for (int i = 0; i < 40; i++) begin
         logic [31:0] x;
         logic [1:0]  op;
         op = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       x = $urandom;
            1:       x = 32'h1 << $urandom_range(0, 31);
            2:       x = $urandom & $urandom & $urandom;
            default: x = $urandom | $urandom;
         endcase
         do_op(op, x, ref_count(op, x), $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
